// File: rtl/key_event.sv
// Key event generator.
// Turns a debounced key level into PRESS / RELEASE / LONG / REPEAT events.
// Events are held in a single-entry valid/ready output register. When an
// event arrives while the register is still full, it is dropped and
// evt_overrun pulses. The FSM never stalls.
module key_event #(
    parameter int unsigned LONG_CYC   = 50000000,
    parameter int unsigned REPEAT_CYC = 10000000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       keyon,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_overrun,
    output logic       held
);

    localparam logic [1:0] CodePress   = 2'b00;
    localparam logic [1:0] CodeRelease = 2'b01;
    localparam logic [1:0] CodeLong    = 2'b10;
    localparam logic [1:0] CodeRepeat  = 2'b11;

    // Terminal counts; cnt is cleared on these, so it never wraps.
    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYC - 32'd1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYC - 32'd1);

    typedef enum logic [1:0] {StIdle, StPressed, StHold} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             prev_q;
    logic             held_q;
    logic             gen_valid_q;
    logic [1:0]       gen_code_q;
    logic             rise;

    // prev_q resets to 1 so a key already down at reset release is ignored.
    assign rise = keyon & ~prev_q;
    assign held = held_q;

    // Key FSM: tracks press state and hold timing, and emits one-cycle event pulses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            prev_q      <= 1'b1;
            held_q      <= 1'b0;
            gen_valid_q <= 1'b0;
            gen_code_q  <= CodePress;
        end else begin
            prev_q      <= keyon;
            gen_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_q     <= StPressed;
                        held_q      <= 1'b1;
                        cnt_q       <= '0;
                        gen_valid_q <= 1'b1;
                        gen_code_q  <= CodePress;
                    end
                end
                StPressed: begin
                    // Release wins over the long-press terminal count.
                    if (!keyon) begin
                        state_q     <= StIdle;
                        held_q      <= 1'b0;
                        gen_valid_q <= 1'b1;
                        gen_code_q  <= CodeRelease;
                    end else if (cnt_q == LongLast) begin
                        state_q     <= StHold;
                        cnt_q       <= '0;
                        gen_valid_q <= 1'b1;
                        gen_code_q  <= CodeLong;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StHold: begin
                    if (!keyon) begin
                        state_q     <= StIdle;
                        held_q      <= 1'b0;
                        gen_valid_q <= 1'b1;
                        gen_code_q  <= CodeRelease;
                    end else if (cnt_q == RepeatLast) begin
                        cnt_q       <= '0;
                        gen_valid_q <= 1'b1;
                        gen_code_q  <= CodeRepeat;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: loads new events when empty or draining this edge, else drops them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            evt_valid   <= 1'b0;
            evt_code    <= CodePress;
            evt_overrun <= 1'b0;
        end else begin
            evt_overrun <= 1'b0;
            if (gen_valid_q) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_code  <= gen_code_q;
                end else begin
                    evt_overrun <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with LONG_CYC=8, REPEAT_CYC=4.
// Each table row gives the inputs for one cycle and the outputs expected
// at the falling edge of that cycle, which reflect all earlier rising edges.
module tb_key_event;

    logic       clock = 1'b0;
    logic       resetn;
    logic       keyon;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       evt_overrun;
    logic       held;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       k;
        logic       r;
        logic       v;
        logic [1:0] c;
        logic       o;
        logic       h;
    } vec_t;

    vec_t vecs[$];

    key_event #(
        .LONG_CYC   (8),
        .REPEAT_CYC (4),
        .CNT_W      (4)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .keyon       (keyon),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ready   (evt_ready),
        .evt_overrun (evt_overrun),
        .held        (held)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    function automatic void add(input logic k, input logic r, input logic v,
                                input logic [1:0] c, input logic o, input logic h);
        vec_t t;
        t.k = k;
        t.r = r;
        t.v = v;
        t.c = c;
        t.o = o;
        t.h = h;
        vecs.push_back(t);
    endfunction

    initial begin
        // Short press (5 cycles): PRESS then RELEASE.
        add(0, 1, 0, 2'b00, 0, 0);
        add(1, 1, 0, 2'b00, 0, 0);
        add(1, 1, 0, 2'b00, 0, 1);
        add(1, 1, 1, 2'b00, 0, 1);
        add(1, 1, 0, 2'b00, 0, 1);
        add(1, 1, 0, 2'b00, 0, 1);
        add(0, 1, 0, 2'b00, 0, 1);
        add(0, 1, 0, 2'b00, 0, 0);
        add(0, 1, 1, 2'b01, 0, 0);
        add(0, 1, 0, 2'b00, 0, 0);
        // Long press, 20 cycles: PRESS, LONG at +8, REPEAT at +12/+16, RELEASE.
        for (int j = 0; j < 24; j++) begin
            logic       v;
            logic [1:0] c;
            v = 1'b0;
            c = 2'b00;
            if (j == 2) v = 1'b1;
            if (j == 10) begin v = 1'b1; c = 2'b10; end
            if (j == 14 || j == 18) begin v = 1'b1; c = 2'b11; end
            if (j == 22) begin v = 1'b1; c = 2'b01; end
            add(j < 20, 1'b1, v, c, 1'b0, j >= 1 && j <= 20);
        end
        // Back-pressure: PRESS held, LONG dropped with one overrun pulse.
        for (int j = 0; j < 16; j++) begin
            logic       v;
            logic [1:0] c;
            v = (j >= 2 && j <= 12) || j == 14;
            c = (j == 14) ? 2'b01 : 2'b00;
            add(j < 12, j >= 12, v, c, j == 10, j >= 1 && j <= 12);
        end
        // Back-to-back: PRESS drains on the edge LONG loads, no gap.
        for (int j = 0; j < 14; j++) begin
            logic       v;
            logic [1:0] c;
            v = (j >= 2 && j <= 10) || j == 12;
            c = (j == 10) ? 2'b10 : ((j == 12) ? 2'b01 : 2'b00);
            add(j < 10, j >= 9, v, c, 1'b0, j >= 1 && j <= 10);
        end
        // Release on the LONG terminal cycle: RELEASE only.
        for (int j = 0; j < 13; j++) begin
            logic       v;
            logic [1:0] c;
            v = (j == 2) || (j == 10);
            c = (j == 10) ? 2'b01 : 2'b00;
            add(j < 8, 1'b1, v, c, 1'b0, j >= 1 && j <= 8);
        end

        resetn    = 1'b0;
        keyon     = 1'b0;
        evt_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_valid", {7'd0, evt_valid}, 8'd0);
        chk("reset_code", {6'd0, evt_code}, 8'd0);
        chk("reset_overrun", {7'd0, evt_overrun}, 8'd0);
        chk("reset_held", {7'd0, held}, 8'd0);
        @(posedge clock);
        #1 resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [7:0] got;
            logic [7:0] exp;
            @(posedge clock);
            #1;
            keyon     = vecs[i].k;
            evt_ready = vecs[i].r;
            @(negedge clock);
            got = {3'd0, evt_valid, (vecs[i].v ? evt_code : 2'b00), evt_overrun, held};
            exp = {3'd0, vecs[i].v, (vecs[i].v ? vecs[i].c : 2'b00), vecs[i].o, vecs[i].h};
            chk($sformatf("row%0d", i), got, exp);
        end

        // Asynchronous reset while in HOLD with an event pending.
        @(posedge clock);
        #1;
        evt_ready = 1'b0;
        keyon     = 1'b1;
        repeat (12) @(posedge clock);
        @(negedge clock);
        chk("pre_reset_valid_held", {6'd0, evt_valid, held}, 8'b11);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_valid", {7'd0, evt_valid}, 8'd0);
        chk("async_reset_code", {6'd0, evt_code}, 8'd0);
        chk("async_reset_overrun", {7'd0, evt_overrun}, 8'd0);
        chk("async_reset_held", {7'd0, held}, 8'd0);

        // Release reset with the key still down: no event until it is seen 0 then 1.
        evt_ready = 1'b1;
        @(negedge clock);
        #1 resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("held_key_quiet%0d", i), {6'd0, evt_valid, held}, 8'd0);
        end
        @(posedge clock);
        #1 keyon = 1'b0;
        @(posedge clock);
        #1 keyon = 1'b1;
        @(negedge clock);
        chk("repress_idle", {6'd0, evt_valid, held}, 8'b00);
        @(negedge clock);
        chk("repress_held", {6'd0, evt_valid, held}, 8'b01);
        @(negedge clock);
        chk("repress_press", {5'd0, evt_valid, evt_code}, 8'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL have parameter LONG_CYC, default 50000000: cycles from press event to long-press event.
REQ-002 SHALL have parameter REPEAT_CYC, default 10000000: cycles between successive repeat events.
REQ-003 SHALL have parameter CNT_W, default 26: hold-counter width; LONG_CYC and REPEAT_CYC SHALL each be ≥2 and ≤2^CNT_W.
REQ-004 SHALL have port clock  input  1: sole clock; all state SHALL change on its rising edge.
REQ-005 SHALL have port resetn  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port keyon  input  1: debounced key level, 1 = pressed; already synchronous to clock.
REQ-007 SHALL have port evt_valid  output  1: an event is held in the output register.
REQ-008 SHALL have port evt_code  output  2: event code; 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT.
REQ-009 SHALL have port evt_ready  input  1: the consumer accepts the event.
REQ-010 SHALL have port evt_overrun  output  1: one-cycle pulse when a generated event is dropped.
REQ-011 SHALL have port held  output  1: 1 while the FSM is not in IDLE.

Function
REQ-012 SHALL register keyon into prev each cycle; rise = keyon & !prev.
REQ-013 SHALL implement the FSM states IDLE, PRESSED and HOLD, with a hold counter cnt of CNT_W bits.
REQ-014 IDLE: on rise, SHALL go to PRESSED, generate PRESS and clear cnt; otherwise SHALL stay in IDLE.
REQ-015 PRESSED: keyon=0 SHALL go to IDLE and generate RELEASE.
REQ-016 PRESSED: keyon=1 with cnt=LONG_CYC-1 SHALL go to HOLD, generate LONG and clear cnt.
REQ-017 PRESSED: in all other cases, SHALL increment cnt.
REQ-018 HOLD: keyon=0 SHALL go to IDLE and generate RELEASE.
REQ-019 HOLD: keyon=1 with cnt=REPEAT_CYC-1 SHALL generate REPEAT and clear cnt.
REQ-020 HOLD: in all other cases, SHALL increment cnt.
REQ-021 RELEASE SHALL take priority over LONG/REPEAT in the same cycle.
REQ-022 cnt SHALL never wrap; it is cleared before reaching the terminal value.
REQ-023 Timing: PRESS SHALL appear on evt_valid one cycle after the first clock edge that samples keyon=1.
REQ-024 Timing: LONG SHALL be generated exactly LONG_CYC cycles after PRESS is generated.
REQ-025 Timing: each REPEAT SHALL follow the previous LONG or REPEAT by exactly REPEAT_CYC cycles.
REQ-026 Output register: a generated event SHALL load evt_code and set evt_valid on the next edge.
REQ-027 Output register: evt_code SHALL stay stable while evt_valid=1.
REQ-028 Output register: a transfer occurs on an edge with evt_valid & evt_ready; evt_valid SHALL then clear unless a new event loads on the same edge.
REQ-029 Same-edge transfer and new event: the new event SHALL load with no loss and no gap cycle.
REQ-030 Event generated while evt_valid=1 and evt_ready=0: the new event SHALL be dropped, the held event kept, and evt_overrun asserted for exactly one cycle.
REQ-031 FSM progression SHALL be independent of evt_ready; there is no back-pressure on the FSM.
REQ-032 held SHALL be 1 in PRESSED and HOLD, and 0 in IDLE.
REQ-033 A key released before LONG SHALL yield exactly PRESS then RELEASE.

Reset
REQ-034 While resetn=0: state SHALL be IDLE, cnt=0, evt_valid=0, evt_code=00, evt_overrun=0, held=0, prev=1.
REQ-035 Because prev resets to 1, a key already held at reset release SHALL generate no event until keyon is seen 0 then 1.
REQ-036 Reset asserted mid-press or mid-handshake SHALL discard the pending event immediately, asynchronously.

Verification (LONG_CYC=8, REPEAT_CYC=4)
REQ-037 Short press: keyon=1 for 5 cycles, evt_ready=1 -> PRESS then RELEASE, no LONG; held high 5 cycles.
REQ-038 Long press with repeat: keyon=1 for 20 cycles -> PRESS; LONG 8 cycles later; REPEAT at +4 and +8 after LONG; then RELEASE; no overrun.
REQ-039 Back-pressure: evt_ready=0, keyon=1 for 12 cycles -> PRESS held stable; LONG dropped with one overrun pulse; once evt_ready=1, PRESS transfers.
REQ-040 Back-to-back: evt_ready raised in the same cycle LONG is generated -> PRESS transfers; LONG becomes valid next cycle without a gap.
REQ-041 Reset: resetn low during HOLD with evt_valid=1 -> all outputs 0 asynchronously.
REQ-042 Reset with key held: release resetn with keyon=1 -> no event; keyon 0 then 1 -> PRESS.
REQ-043 Release priority: keyon falls on the LONG terminal cycle -> RELEASE only, no LONG.
